ifetch_unit: RTL and testbench
==============================

Name: ifetch_unit

Overview:
- Instruction fetch stage of the CPU. Holds the PC and runs a req/ready handshake to instruction memory.
- Latches the fetched word into an instruction register and splits out imm16, which feeds the immediate extender.
- On each advance, computes the next PC (sequential, branch, jump, jr). The branch path uses the 32-bit extended immediate that the extender returns.

Parameters:
- RESET_PC, 32'h0000_3000, PC value loaded on reset.
- NOP_WORD, 32'h0000_0000, IR contents while no valid instruction is held.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- imem_req  out  1  fetch request to instruction memory.
- imem_addr  out  32  fetch address; always equals pc.
- imem_rdata  in  32  instruction word; sampled only when imem_req && imem_ready.
- imem_ready  in  1  memory accepts the request and returns data this cycle.
- stall  in  1  downstream hold; freezes IR and PC while instr_valid=1.
- npc_sel  in  2  next-PC source: 00 seq, 01 branch, 10 j/jal, 11 jr.
- br_taken  in  1  branch condition; used only when npc_sel=01.
- ext_imm  in  32  extended immediate returned by the extender.
- jr_target  in  32  register value for jr.
- instr  out  32  instruction register.
- imm16  out  16  instr[15:0], to the extender.
- instr_valid  out  1  instr holds a valid fetched word.
- pc  out  32  address of the word in instr.
- pc_plus4  out  32  pc+4, used as the jal link value.
- addr_err  out  1  one-cycle pulse when a jr target is misaligned.

Behaviour:
- Reset (rst=1 at a clock edge; takes priority over everything, including mid-handshake):
  - pc=RESET_PC, instr=NOP_WORD, instr_valid=0, addr_err=0, state=FETCH.
  - imem_req=1 from the first cycle after reset.
- FSM has two states, FETCH and HOLD.
- FETCH:
  - imem_req=1, imem_addr=pc.
  - If imem_ready=1: instr<=imem_rdata, instr_valid<=1, go to HOLD.
  - Otherwise stay in FETCH; instr keeps NOP_WORD and instr_valid stays 0.
  - stall is ignored in FETCH.
- HOLD:
  - imem_req=0.
  - If stall=1: hold all state.
  - If stall=0 (advance): pc<=npc, instr<=NOP_WORD, instr_valid<=0, go to FETCH.
- Latency: instruction appears one cycle after the ready cycle. With zero-wait memory, throughput is one instruction per 2 cycles.
- npc is combinational from the current pc/instr:
  - 00: pc+4.
  - 01: pc+4+(ext_imm<<2) if br_taken, else pc+4.
  - 10: {pc_plus4[31:28], instr[25:0], 2'b00}.
  - 11: {jr_target[31:2], 2'b00}. If jr_target[1:0]!=0, addr_err=1 for exactly the cycle after the advance; the PC is still loaded with the target's low two bits cleared.
- Arithmetic: all sums are modulo 2^32. pc=32'hFFFF_FFFC sequential gives 0. Negative ext_imm is handled by ordinary two's-complement add.
- imm16 and pc_plus4 are continuous combinational functions of instr and pc.
- npc_sel, br_taken, ext_imm and jr_target are sampled only on an advance edge.

Decomposition:
- Shared package (cpu_pkg):
  - NPC_SEQ/NPC_BR/NPC_J/NPC_JR encodings for npc_sel.
  - RESET_PC default.
  - NOP_WORD.
  - FSM state encoding (FETCH=0, HOLD=1).
- One sub-module, npc_calc: purely combinational, computes npc and the misalignment flag from pc, instr, npc_sel, br_taken, ext_imm and jr_target.
- ifetch_unit holds the PC/IR registers, the FSM and the addr_err pulse register.

Test Plan:
- Reset then imem_ready=1 with rdata=32'h2408_0005 → imem_addr=32'h0000_3000; next cycle instr=32'h2408_0005, imm16=16'h0005, instr_valid=1, pc_plus4=32'h0000_3004.
- Zero-wait, three sequential advances → imem_addr sequence 3000, 3004, 3008. imem_req alternates 1/0, never asserted in HOLD.
- Branch at pc=32'h0000_3010, ext_imm=32'hFFFF_FFFE, br_taken=1 → next imem_addr=32'h0000_300C. Same case with br_taken=0 → 32'h0000_3014.
- j with instr[25:0]=26'h0000C40 at pc=32'h0000_3000 → next pc=32'h0000_3100. jr with jr_target=32'h0000_3042 → pc=32'h0000_3040 and a single-cycle addr_err pulse.
- imem_ready held low 4 cycles, then stall=1 for 3 cycles in HOLD:
  - during the wait: instr_valid=0 and imem_addr stable;
  - during the stall: instr/pc unchanged;
  - the advance happens only on the first stall=0 edge.
- rst asserted while in FETCH with imem_ready=0, and separately in HOLD with stall=1 → next cycle pc=32'h0000_3000, instr=0, instr_valid=0, imem_req=1. A pc=32'hFFFF_FFFC sequential advance gives imem_addr=0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the fetch stage: next-PC source encodings,
// reset defaults and the fetch FSM state type.
package cpu_pkg;

  localparam logic [1:0] NPC_SEQ = 2'b00;
  localparam logic [1:0] NPC_BR  = 2'b01;
  localparam logic [1:0] NPC_J   = 2'b10;
  localparam logic [1:0] NPC_JR  = 2'b11;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;
  localparam logic [31:0] NOP_WORD_DEFAULT = 32'h0000_0000;

  typedef enum logic {
    FETCH = 1'b0,
    HOLD  = 1'b1
  } fetch_state_t;

  // A word address must have its two low bits clear.
  function automatic logic word_misaligned(input logic [31:0] addr);
    return (addr[1:0] != 2'b00);
  endfunction

endpackage

// File: rtl/ifetch_unit_npc_calc.sv
// Combinational next-PC selection for the fetch stage, plus the flag that
// marks a jr target with nonzero low address bits.
module npc_calc
  import cpu_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [31:0] instr,
  input  logic [1:0]  npc_sel,
  input  logic        br_taken,
  input  logic [31:0] ext_imm,
  input  logic [31:0] jr_target,
  output logic [31:0] npc,
  output logic        misalign
);

  logic [31:0] seq_s;
  logic [31:0] br_s;

  assign seq_s = pc + 32'd4;
  assign br_s  = seq_s + {ext_imm[29:0], 2'b00};

  // Pick the next fetch address; jr always drops the low two bits.
  always_comb begin
    npc      = seq_s;
    misalign = 1'b0;
    case (npc_sel)
      NPC_SEQ: npc = seq_s;
      NPC_BR: begin
        if (br_taken) begin
          npc = br_s;
        end else begin
          npc = seq_s;
        end
      end
      NPC_J:   npc = {seq_s[31:28], instr[25:0], 2'b00};
      NPC_JR: begin
        npc      = {jr_target[31:2], 2'b00};
        misalign = word_misaligned(jr_target);
      end
      default: npc = seq_s;
    endcase
  end

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch stage: PC and instruction registers, a FETCH/HOLD
// handshake with instruction memory, and a pulse for misaligned jr targets.
module ifetch_unit
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter logic [31:0] NOP_WORD = NOP_WORD_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  input  logic        stall,
  input  logic [1:0]  npc_sel,
  input  logic        br_taken,
  input  logic [31:0] ext_imm,
  input  logic [31:0] jr_target,
  output logic [31:0] instr,
  output logic [15:0] imm16,
  output logic        instr_valid,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        addr_err
);

  fetch_state_t state_r;
  fetch_state_t state_s;
  logic [31:0]  pc_r;
  logic [31:0]  instr_r;
  logic         valid_r;
  logic         addr_err_r;
  logic [31:0]  npc_s;
  logic         misalign_s;

  npc_calc u_npc_calc (
    .pc        (pc_r),
    .instr     (instr_r),
    .npc_sel   (npc_sel),
    .br_taken  (br_taken),
    .ext_imm   (ext_imm),
    .jr_target (jr_target),
    .npc       (npc_s),
    .misalign  (misalign_s)
  );

  // Next-state: leave FETCH on ready, leave HOLD when not stalled.
  always_comb begin
    state_s = state_r;
    case (state_r)
      FETCH: begin
        if (imem_ready) begin
          state_s = HOLD;
        end else begin
          state_s = FETCH;
        end
      end
      HOLD: begin
        if (!stall) begin
          state_s = FETCH;
        end else begin
          state_s = HOLD;
        end
      end
      default: state_s = FETCH;
    endcase
  end

  // State, PC/IR registers and the one-cycle addr_err pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= FETCH;
      pc_r       <= RESET_PC;
      instr_r    <= NOP_WORD;
      valid_r    <= 1'b0;
      addr_err_r <= 1'b0;
    end else begin
      state_r    <= state_s;
      addr_err_r <= 1'b0;
      case (state_r)
        FETCH: begin
          if (imem_ready) begin
            instr_r <= imem_rdata;
            valid_r <= 1'b1;
          end
        end
        HOLD: begin
          if (!stall) begin
            pc_r       <= npc_s;
            instr_r    <= NOP_WORD;
            valid_r    <= 1'b0;
            addr_err_r <= misalign_s;
          end
        end
        default: begin
          instr_r <= NOP_WORD;
          valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req    = (state_r == FETCH);
  assign imem_addr   = pc_r;
  assign pc          = pc_r;
  assign instr       = instr_r;
  assign imm16       = instr_r[15:0];
  assign instr_valid = valid_r;
  assign pc_plus4    = pc_r + 32'd4;
  assign addr_err    = addr_err_r;

endmodule

// File: tb/tb_ifetch_unit.sv
// Self-checking bench for ifetch_unit: directed scenarios from the fetch
// rules plus a randomized run compared against a behavioural model.
module tb_ifetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ready;
  logic        stall;
  logic [1:0]  npc_sel;
  logic        br_taken;
  logic [31:0] ext_imm;
  logic [31:0] jr_target;
  logic [31:0] instr;
  logic [15:0] imm16;
  logic        instr_valid;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        addr_err;

  int errors = 0;
  int checks = 0;

  // Behavioural model: "waiting for memory" is simply !m_valid.
  logic [31:0] m_pc;
  logic [31:0] m_instr;
  logic        m_valid;
  logic        m_err;

  ifetch_unit dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .imem_ready(imem_ready), .stall(stall),
    .npc_sel(npc_sel), .br_taken(br_taken), .ext_imm(ext_imm),
    .jr_target(jr_target), .instr(instr), .imm16(imm16),
    .instr_valid(instr_valid), .pc(pc), .pc_plus4(pc_plus4), .addr_err(addr_err)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_npc();
    logic [31:0] seq;
    seq = m_pc + 32'd4;
    case (npc_sel)
      2'd1:    return br_taken ? seq + ext_imm * 32'd4 : seq;
      2'd2:    return (seq & 32'hF000_0000) | ((m_instr & 32'h03FF_FFFF) * 32'd4);
      2'd3:    return jr_target & ~32'd3;
      default: return seq;
    endcase
  endfunction

  // One clock edge: update the model from the inputs seen at the edge.
  task automatic cycle();
    @(posedge clk);
    if (rst) begin
      m_pc = 32'h0000_3000; m_instr = 32'd0; m_valid = 1'b0; m_err = 1'b0;
    end else begin
      m_err = 1'b0;
      if (!m_valid) begin
        if (imem_ready) begin
          m_instr = imem_rdata; m_valid = 1'b1;
        end
      end else if (!stall) begin
        m_err   = (npc_sel == 2'd3) && (jr_target % 32'd4 != 32'd0);
        m_pc    = ref_npc();
        m_instr = 32'd0;
        m_valid = 1'b0;
      end
    end
    #1;
  endtask

  // From HOLD: jr to a target, then complete one fetch of word w.
  task automatic goto_pc(input logic [31:0] target, input logic [31:0] w);
    stall = 1'b0; npc_sel = 2'd3; jr_target = target; imem_ready = 1'b0;
    cycle();
    imem_ready = 1'b1; imem_rdata = w;
    cycle();
    imem_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; imem_ready = 1'b0; imem_rdata = 32'd0; stall = 1'b0;
    npc_sel = 2'd0; br_taken = 1'b0; ext_imm = 32'd0; jr_target = 32'd0;
    cycle(); cycle();
    rst = 1'b0;
    checks++; if (pc !== 32'h0000_3000) begin errors++; $display("FAIL reset_pc got %h exp 00003000", pc); end
    checks++; if (instr !== 32'd0) begin errors++; $display("FAIL reset_instr got %h exp 0", instr); end
    checks++; if (instr_valid !== 1'b0 || addr_err !== 1'b0) begin errors++; $display("FAIL reset_flags valid=%b err=%b exp 0/0", instr_valid, addr_err); end
    checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL reset_req got %b exp 1", imem_req); end
  endtask

  task automatic test_first_fetch();
    checks++; if (imem_addr !== 32'h0000_3000) begin errors++; $display("FAIL first_addr got %h exp 00003000", imem_addr); end
    imem_ready = 1'b1; imem_rdata = 32'h2408_0005;
    cycle();
    imem_ready = 1'b0;
    checks++; if (instr !== 32'h2408_0005 || imm16 !== 16'h0005) begin errors++; $display("FAIL first_instr got %h/%h exp 24080005/0005", instr, imm16); end
    checks++; if (instr_valid !== 1'b1 || pc_plus4 !== 32'h0000_3004) begin errors++; $display("FAIL first_valid got %b/%h exp 1/00003004", instr_valid, pc_plus4); end
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL first_req_hold got %b exp 0", imem_req); end
  endtask

  task automatic test_sequential();
    logic [31:0] exp_addr;
    stall = 1'b0; npc_sel = 2'd0; imem_ready = 1'b1;
    for (int i = 1; i <= 2; i++) begin
      exp_addr = 32'h0000_3000 + 32'd4 * i;
      cycle();
      checks++; if (imem_req !== 1'b1 || imem_addr !== exp_addr) begin errors++; $display("FAIL seq_fetch%0d req=%b addr=%h exp 1/%h", i, imem_req, imem_addr, exp_addr); end
      imem_rdata = $urandom;
      cycle();
      checks++; if (imem_req !== 1'b0 || instr !== imem_rdata) begin errors++; $display("FAIL seq_hold%0d req=%b instr=%h exp 0/%h", i, imem_req, instr, imem_rdata); end
    end
    imem_ready = 1'b0;
  endtask

  task automatic test_branch();
    goto_pc(32'h0000_3010, 32'h1000_FFFE);
    npc_sel = 2'd1; br_taken = 1'b1; ext_imm = 32'hFFFF_FFFE;
    cycle();
    checks++; if (imem_addr !== 32'h0000_300C) begin errors++; $display("FAIL br_taken got %h exp 0000300c", imem_addr); end
    imem_ready = 1'b1; cycle(); imem_ready = 1'b0;
    goto_pc(32'h0000_3010, 32'h1000_FFFE);
    npc_sel = 2'd1; br_taken = 1'b0;
    cycle();
    checks++; if (imem_addr !== 32'h0000_3014) begin errors++; $display("FAIL br_not_taken got %h exp 00003014", imem_addr); end
    imem_ready = 1'b1; cycle(); imem_ready = 1'b0;
  endtask

  task automatic test_jump();
    goto_pc(32'h0000_3000, 32'h0800_0C40);
    npc_sel = 2'd2;
    cycle();
    checks++; if (pc !== 32'h0000_3100) begin errors++; $display("FAIL j_target got %h exp 00003100", pc); end
    imem_ready = 1'b1; cycle(); imem_ready = 1'b0;
    npc_sel = 2'd3; jr_target = 32'h0000_3042;
    cycle();
    checks++; if (pc !== 32'h0000_3040 || addr_err !== 1'b1) begin errors++; $display("FAIL jr_misalign pc=%h err=%b exp 00003040/1", pc, addr_err); end
    imem_ready = 1'b1; cycle(); imem_ready = 1'b0;
    checks++; if (addr_err !== 1'b0) begin errors++; $display("FAIL jr_err_pulse got %b exp 0", addr_err); end
  endtask

  task automatic test_wait_stall();
    logic [31:0] held_pc;
    logic [31:0] held_instr;
    stall = 1'b0; npc_sel = 2'd0;
    cycle();
    held_pc = imem_addr;
    for (int i = 0; i < 4; i++) begin
      stall = (i % 2 == 0);
      cycle();
      checks++; if (instr_valid !== 1'b0 || imem_addr !== held_pc) begin errors++; $display("FAIL wait%0d valid=%b addr=%h exp 0/%h", i, instr_valid, imem_addr, held_pc); end
    end
    imem_ready = 1'b1; imem_rdata = 32'hDEAD_BEEF; stall = 1'b0;
    cycle();
    imem_ready = 1'b0; held_instr = instr;
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      checks++; if (instr !== held_instr || pc !== held_pc || instr_valid !== 1'b1) begin errors++; $display("FAIL stall%0d instr=%h pc=%h exp %h/%h", i, instr, pc, held_instr, held_pc); end
    end
    stall = 1'b0;
    cycle();
    checks++; if (instr_valid !== 1'b0 || pc !== held_pc + 32'd4) begin errors++; $display("FAIL stall_release valid=%b pc=%h exp 0/%h", instr_valid, pc, held_pc + 32'd4); end
  endtask

  task automatic test_reset_mid();
    imem_ready = 1'b0; rst = 1'b1;
    cycle();
    rst = 1'b0;
    checks++; if (pc !== 32'h0000_3000 || instr !== 32'd0 || instr_valid !== 1'b0 || imem_req !== 1'b1) begin errors++; $display("FAIL rst_fetch pc=%h instr=%h v=%b req=%b", pc, instr, instr_valid, imem_req); end
    goto_pc(32'h0000_4444, 32'h1234_5678);
    stall = 1'b1; rst = 1'b1;
    cycle();
    rst = 1'b0; stall = 1'b0;
    checks++; if (pc !== 32'h0000_3000 || instr !== 32'd0 || instr_valid !== 1'b0 || imem_req !== 1'b1) begin errors++; $display("FAIL rst_hold pc=%h instr=%h v=%b req=%b", pc, instr, instr_valid, imem_req); end
  endtask

  task automatic test_wrap();
    imem_ready = 1'b1; cycle(); imem_ready = 1'b0;
    goto_pc(32'hFFFF_FFFC, 32'd0);
    npc_sel = 2'd0;
    cycle();
    checks++; if (imem_addr !== 32'd0) begin errors++; $display("FAIL pc_wrap got %h exp 00000000", imem_addr); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      rst        = ($urandom_range(0, 60) == 0);
      imem_ready = $urandom_range(0, 1);
      imem_rdata = $urandom;
      stall      = ($urandom_range(0, 3) == 0);
      npc_sel    = 2'($urandom_range(0, 3));
      br_taken   = $urandom_range(0, 1);
      ext_imm    = 32'($signed(16'($urandom)));
      jr_target  = $urandom;
      cycle();
      checks++;
      if (pc !== m_pc || instr !== m_instr || instr_valid !== m_valid || addr_err !== m_err ||
          imem_req !== !m_valid || imem_addr !== m_pc || imm16 !== m_instr[15:0] ||
          pc_plus4 !== m_pc + 32'd4) begin
        errors++;
        $display("FAIL rand%0d pc=%h/%h instr=%h/%h v=%b/%b err=%b/%b req=%b", i, pc, m_pc,
                 instr, m_instr, instr_valid, m_valid, addr_err, m_err, imem_req);
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_first_fetch();
    test_sequential();
    test_branch();
    test_jump();
    test_wait_stall();
    test_reset_mid();
    test_wrap();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
